pipelined_alu: RTL and testbench

- Parametrised, two-stage pipelined successor to the 6-bit combinational mini ALU.
- Keeps the 8-function fxn encoding.
- Adds: generic WIDTH, valid/ready handshakes on input and output, a status flag set, optional signed saturation, and an internal accumulator usable as operand A.
- Sits between an operand source (switch/register-file front end) and a result consumer (display/writeback).

---
 rtl/pipelined_alu.sv | 175 +++++++++++++++++
 tb/tb_pipelined_alu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// ============================================================================
//  Module      : pipelined_alu
//  Description : Two-stage valid/ready pipelined ALU with status flags,
//                optional signed saturation and an accumulator operand.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_alu #(
    parameter int WIDTH    = 6,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       fxn,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] X,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] C_PASS_A = 3'b000;
    localparam logic [2:0] C_PASS_B = 3'b001;
    localparam logic [2:0] C_NEG_A  = 3'b010;
    localparam logic [2:0] C_NEG_B  = 3'b011;
    localparam logic [2:0] C_SLT    = 3'b100;
    localparam logic [2:0] C_XNOR   = 3'b101;
    localparam logic [2:0] C_ADD    = 3'b110;
    localparam logic [2:0] C_SUB    = 3'b111;

    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_MAX = ~C_MIN;
    localparam int               C_MSB = WIDTH - 1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_fxn;
    logic             r_acc_en;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_x;
    logic             r_zero;
    logic             r_neg;
    logic             r_carry;
    logic             r_ovf;
    logic [WIDTH-1:0] r_acc;

    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_raw;
    logic             w_carry;
    logic             w_ovf;
    logic [WIDTH-1:0] w_x;

    assign w_s1_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = !r_s1_valid || w_s1_adv;
    assign w_accept = in_valid && in_ready;

    // Accumulator is sampled when the op leaves stage 1, so a dependent op
    // right behind always sees the freshly written value.
    assign w_opa  = r_acc_en ? r_acc : r_a;
    assign w_sum  = {1'b0, w_opa} + {1'b0, r_b};
    assign w_diff = {1'b0, w_opa} - {1'b0, r_b};

    always_comb begin
        w_raw   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_fxn)
            C_PASS_A: w_raw = w_opa;
            C_PASS_B: w_raw = r_b;
            C_NEG_A: begin
                w_raw = -w_opa;
                w_ovf = (w_opa == C_MIN);
            end
            C_NEG_B: begin
                w_raw = -r_b;
                w_ovf = (r_b == C_MIN);
            end
            C_SLT:    w_raw = {{(WIDTH-1){1'b0}}, ($signed(w_opa) < $signed(r_b))};
            C_XNOR:   w_raw = ~(w_opa ^ r_b);
            C_ADD: begin
                w_raw   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_opa[C_MSB] == r_b[C_MSB]) && (w_sum[C_MSB] != w_opa[C_MSB]);
            end
            C_SUB: begin
                w_raw   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (w_opa[C_MSB] != r_b[C_MSB]) && (w_diff[C_MSB] != w_opa[C_MSB]);
            end
            default: w_raw = '0;
        endcase
    end

    // A wrapped result always carries the wrong sign, so the raw MSB tells
    // which rail to clamp to.
    assign w_x = ((SATURATE != 0) && w_ovf) ? (w_raw[C_MSB] ? C_MAX : C_MIN) : w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_fxn      <= '0;
            r_acc_en   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_a        <= A;
                r_b        <= B;
                r_fxn      <= fxn;
                r_acc_en   <= acc_en;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_x        <= '0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_x        <= w_x;
                r_zero     <= (w_x == '0);
                r_neg      <= w_x[C_MSB];
                r_carry    <= w_carry;
                r_ovf      <= w_ovf;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (acc_clr) begin
            r_acc <= '0;
        end else if (w_s1_adv && r_acc_en) begin
            r_acc <= w_x;
        end
    end

    assign out_valid = r_s2_valid;
    assign X         = r_x;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign acc       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_alu.sv
// ============================================================================
//  Module      : tb_pipelined_alu
//  Description : Self-checking bench; wrapping and saturating instances share
//                stimulus and are scored against an integer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_alu;

    localparam int W    = 6;
    localparam int M    = 1 << W;
    localparam int HALF = M / 2;

    typedef struct {
        int x;
        bit c;
        bit v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, acc_en, acc_clr, out_ready;
    logic [W-1:0] A, B;
    logic [2:0]   fxn;
    logic         in_ready0, out_valid0, zero0, neg0, carry0, ovf0;
    logic         in_ready1, out_valid1, zero1, neg1, carry1, ovf1;
    logic [W-1:0] x0, acc0, x1, acc1;

    int   n_total = 0;
    int   n_bad   = 0;
    int   macc [2];
    res_t q0[$];
    res_t q1[$];
    bit   prev_stall;
    logic [W-1:0] held0, held1;
    logic rdy_seen;

    always #5 clk = ~clk;

    pipelined_alu #(.WIDTH(W), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .A(A), .B(B), .fxn(fxn), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid0), .out_ready(out_ready), .X(x0), .zero(zero0),
        .neg(neg0), .carry(carry0), .ovf(ovf0), .acc(acc0)
    );

    pipelined_alu #(.WIDTH(W), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .fxn(fxn), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .X(x1), .zero(zero1),
        .neg(neg1), .carry(carry1), .ovf(ovf1), .acc(acc1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Operates on signed integers and clamps/wraps by value range.
    function automatic res_t model(input int a, input int b, input int f, input bit sat);
        res_t r;
        int   sa, sb, v;
        bit   arith;
        sa = (a >= HALF) ? a - M : a;
        sb = (b >= HALF) ? b - M : b;
        r.x = 0; r.c = 0; r.v = 0; v = 0; arith = 0;
        case (f)
            0: r.x = a;
            1: r.x = b;
            2: begin v = -sa; arith = 1; end
            3: begin v = -sb; arith = 1; end
            4: r.x = (sa < sb) ? 1 : 0;
            5: r.x = (~(a ^ b)) & (M - 1);
            6: begin v = sa + sb; r.c = ((a + b) >= M); arith = 1; end
            default: begin v = sa - sb; r.c = (a < b); arith = 1; end
        endcase
        if (arith) begin
            r.v = (v > HALF - 1) || (v < -HALF);
            if (r.v && sat) r.x = (v > 0) ? HALF - 1 : HALF;
            else            r.x = v & (M - 1);
        end
        return r;
    endfunction

    task automatic score(input string tag, input res_t e, input logic [W-1:0] x,
                         input logic z, input logic n, input logic c, input logic v);
        check({tag, "_x"},    x, e.x);
        check({tag, "_zero"}, z, (e.x == 0));
        check({tag, "_neg"},  n, (e.x >= HALF));
        check({tag, "_carry"}, c, e.c);
        check({tag, "_ovf"},  v, e.v);
    endtask

    // One clock: evaluate handshakes just after the falling edge, then wait
    // for the next falling edge. Inputs are set by the caller beforehand.
    task automatic step(output bit acc_ok);
        res_t e, r;
        int   a;
        #1;
        rdy_seen = in_ready0;
        if (prev_stall) begin
            check("hold0", x0, held0);
            check("hold1", x1, held1);
        end
        if (out_valid0 && out_ready) begin
            if (q0.size() == 0) check("spurious0", 1, 0);
            else begin e = q0.pop_front(); score("wrap", e, x0, zero0, neg0, carry0, ovf0); end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) check("spurious1", 1, 0);
            else begin e = q1.pop_front(); score("sat", e, x1, zero1, neg1, carry1, ovf1); end
        end
        prev_stall = out_valid0 && !out_ready;
        held0 = x0;
        held1 = x1;
        if (acc_clr) begin macc[0] = 0; macc[1] = 0; end
        acc_ok = in_valid && in_ready0;
        if (acc_ok) begin
            for (int d = 0; d < 2; d++) begin
                a = acc_en ? macc[d] : int'(A);
                r = model(a, int'(B), int'(fxn), d == 1);
                if (acc_en) macc[d] = r.x;
                if (d == 0) q0.push_back(r); else q1.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b, input int f, input bit ae);
        bit ok;
        int n;
        A = W'(a); B = W'(b); fxn = 3'(f); acc_en = ae; in_valid = 1'b1;
        n = 0;
        do begin
            step(ok);
            n++;
        end while (!ok && n < 20);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
            step(ok);
            n++;
        end
        if (n >= 40) check("drain_timeout", 0, 1);
        check("acc_wrap", acc0, macc[0]);
        check("acc_sat",  acc1, macc[1]);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return HALF;
            2: return HALF - 1;
            3: return M - 1;
            default: return int'($urandom_range(0, M - 1));
        endcase
    endfunction

    initial begin
        bit ok;
        int idx;
        rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; fxn = '0;
        macc[0] = 0; macc[1] = 0; prev_stall = 0;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_valid", out_valid0, 0);
        check("rst_x", x0, 0);
        check("rst_acc", acc0, 0);
        check("rst_ready", in_ready0, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // add with carry, then subtract with borrow; first one timed
        send(6'b111000, 6'b111000, 6, 0);
        in_valid = 1'b0;
        #1 check("lat_edge1", out_valid0, 0);
        @(negedge clk);
        #1 check("lat_edge2", out_valid0, 1);
        check("lat_x", x0, 6'b110000);
        drain();
        send(6'b000101, 6'b001111, 7, 0);
        drain();

        // signed compare
        send(6'b010101, 6'b101111, 4, 0);
        send(6'b100101, 6'b101111, 4, 0);
        send(6'b111111, 6'b111111, 4, 0);
        drain();

        // overflow: add past max, negate of min
        send(6'b011111, 6'b000001, 6, 0);
        send(6'b100000, 6'b000000, 2, 0);
        drain();

        // accumulator chain, then clear coincident with a 4th op
        acc_clr = 1'b1; step(ok); acc_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 5, 6, 1);
        drain();
        check("acc_after3", acc0, 15);
        send(0, 5, 6, 1);
        in_valid = 1'b0; acc_clr = 1'b1; step(ok); acc_clr = 1'b0;
        drain();
        check("acc_after_clr", acc0, 0);

        // backpressure
        idx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = (cyc >= 4);
            if (idx < 5) begin
                A = W'(idx * 7 + 1); B = W'(idx * 3 + 2); fxn = 3'd5; acc_en = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step(ok);
            if (cyc == 2 || cyc == 3) check("bp_in_ready", rdy_seen, 0);
            if (ok) idx++;
            if (idx == 5 && q0.size() == 0) break;
        end
        check("bp_accepted", idx, 5);
        drain();

        // randomized mix
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 4) != 0);
                A = W'(pick()); B = W'(pick());
                fxn = 3'($urandom_range(0, 7));
                acc_en = ($urandom_range(0, 3) == 0);
            end
            step(ok);
            if (ok) in_valid = 1'b0;
        end
        drain();

        // asynchronous reset with results in flight
        send(0, 7, 1, 1);
        send(0, 9, 1, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        step(ok); step(ok);
        check("pre_rst_valid", out_valid0, 1);
        check("pre_rst_acc", acc0, 7);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid0", out_valid0, 0);
        check("mid_rst_valid1", out_valid1, 0);
        check("mid_rst_x", x0, 0);
        check("mid_rst_flags", {zero0, neg0, carry0, ovf0}, 0);
        check("mid_rst_acc", acc0, 0);
        q0.delete(); q1.delete();
        macc[0] = 0; macc[1] = 0; prev_stall = 0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check("post_rst_ready", in_ready0, 1);
        check("post_rst_valid", out_valid0, 0);
        @(negedge clk);
        send(6'b000011, 6'b000100, 6, 0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
